// File: rtl/wishbone_master.sv
// Wishbone B3 initiator: single/incrementing bursts, bounded retry, err abort.
// Optional strobe watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master #(
  parameter int LEN_W          = 4,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic [1:0]       err_code_o,
  output logic             busy_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [31:0]      adr_o,
  output logic [31:0]      dat_o,
  output logic [3:0]       sel_o,
  output logic [2:0]       cti_o,
  output logic [1:0]       bte_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic             rty_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, STROBE, BACKOFF, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       sel_q, sel_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [31:0]      dat_q, dat_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             rvld_q, rvld_d;
  logic             last;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    to_q, to_d;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
`endif

  assign last = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    len_d       = len_q;
    sel_d       = sel_q;
    beat_d      = beat_q;
    retry_d     = retry_q;
    dat_d       = dat_q;
    err_d       = err_q;
    rdat_d      = rdat_q;
    rvld_d      = 1'b0;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    done_o      = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    to_d        = '0;
`endif
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i & ~32'h3;
          len_d   = cmd_len_i;
          sel_d   = cmd_sel_i;
          beat_d  = '0;
          retry_d = '0;
          err_d   = 2'b00;
          state_d = cmd_we_i ? FETCH : STROBE;
        end
      end
      FETCH: begin
        cyc_o      = 1'b1;
        wr_ready_o = wr_valid_i;
        if (wr_valid_i) begin
          dat_d   = wr_data_i;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        if (err_i) begin
          err_d   = 2'b01;
          state_d = FINISH;
        end else if (rty_i) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            err_d   = 2'b10;
            state_d = FINISH;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = BACKOFF;
          end
        end else if (ack_i) begin
          if (!we_q) begin
            rdat_d = dat_i;
            rvld_d = 1'b1;
          end
          if (last) begin
            state_d = FINISH;
          end else begin
            adr_d   = adr_q + 32'd4;
            beat_d  = beat_q + LEN_W'(1);
            retry_d = '0;
            state_d = we_q ? FETCH : STROBE;
          end
`ifdef WB_MASTER_TIMEOUT_EN
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 2'b11;
          state_d = FINISH;
        end else begin
          to_d = to_q + TW'(1);
`endif
        end
      end
      BACKOFF: begin
        cyc_o   = 1'b1;
        state_d = STROBE;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      retry_q <= '0;
      dat_q   <= '0;
      err_q   <= '0;
      rdat_q  <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) to_q <= '0;
    else            to_q <= to_d;
  end
`endif

  // Single-beat commands are classic cycles; bursts end with 111.
  assign cti_o      = (len_q == '0) ? 3'b000 :
                      (last ? 3'b111 : 3'b010);
  assign bte_o      = 2'b00;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign sel_o      = sel_q;
  assign we_o       = we_q;
  assign err_code_o = err_q;
  assign rd_data_o  = rdat_q;
  assign rd_valid_o = rvld_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_wishbone_master.sv
// Scoreboard bench for wishbone_master with a queue-driven slave model.
// Timeout scenario runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wishbone_master;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_len_i, cmd_sel_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, done_o, busy_o;
  logic [1:0]  err_code_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i, rty_i;

  always #5 clk = ~clk;

  wishbone_master #(
    .LEN_W(4), .MAX_RETRY(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
    .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .done_o(done_o),
    .err_code_o(err_code_o), .busy_o(busy_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .cti_o(cti_o), .bte_o(bte_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    int          dly;
  } wbeat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  int          rq[$];
  wbeat_t      wq[$];
  int          wdly;
  bit          took;
  int          errors = 0;
  int          checks = 0;
  int          n_rd = 0, n_wr = 0, n_done = 0, n_wait = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // Slave: one termination per strobe, one cycle after it is seen.
  task automatic slave_step();
    int code;
    ack_i <= 1'b0;
    err_i <= 1'b0;
    rty_i <= 1'b0;
    if (!(ack_i || err_i || rty_i) && cyc_o && stb_o) begin
      code = (rq.size() != 0) ? rq[0] : 0;
      if (code != 3) begin
        if (rq.size() != 0) void'(rq.pop_front());
        ack_i <= (code == 0);
        rty_i <= (code == 1);
        err_i <= (code == 2);
        dat_i <= pat(adr_o);
      end
    end
  endtask

  task automatic drive_wr();
    if (took) begin
      took = 1'b0;
      if (wq.size() != 0) void'(wq.pop_front());
      if (wq.size() != 0) wdly = wq[0].dly;
    end
    if (wq.size() == 0) begin
      wr_valid_i = 1'b0;
    end else if (wdly > 0) begin
      wr_valid_i = 1'b0;
      if (cyc_o && !stb_o) wdly--;
    end else begin
      wr_valid_i = 1'b1;
      wr_data_i  = wq[0].d;
    end
  endtask

  task automatic monitor();
    beat_t b;
    logic [31:0] e;
    if (rd_valid_o) begin
      n_rd++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %08h want none", rd_data_o);
      end else begin
        e = exp_rd.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL rd_data: got %08h want %08h", rd_data_o, e);
        end
      end
    end
    if (wr_ready_o) n_wr++;
    if (done_o) n_done++;
    if (cyc_o && !stb_o && !wr_valid_i) n_wait++;
    if (cyc_o && stb_o && rty_i && exp_beat.size() != 0) begin
      checks++;
      if (adr_o !== exp_beat[0].adr || (we_o && dat_o !== exp_beat[0].dat)) begin
        errors++;
        $display("FAIL retry_beat: got adr %08h dat %08h want adr %08h dat %08h",
                 adr_o, dat_o, exp_beat[0].adr, exp_beat[0].dat);
      end
    end
    if (cyc_o && stb_o && ack_i) begin
      checks++;
      if (exp_beat.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got adr %08h want none", adr_o);
      end else begin
        b = exp_beat.pop_front();
        if (adr_o !== b.adr || cti_o !== b.cti || we_o !== b.we ||
            sel_o !== b.sel || bte_o !== 2'b00 ||
            (b.we && dat_o !== b.dat)) begin
          errors++;
          $display("FAIL beat: got adr %08h cti %b we %b sel %h bte %b dat %08h want adr %08h cti %b we %b sel %h bte 00 dat %08h",
                   adr_o, cti_o, we_o, sel_o, bte_o, dat_o,
                   b.adr, b.cti, b.we, b.sel, b.dat);
        end
      end
    end
  endtask

  task automatic push_beats(input bit we, input logic [31:0] adr,
                            input int len, input logic [3:0] sel,
                            input logic [31:0] d0);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.adr = adr + 32'(4 * i);
      b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
      b.we  = we;
      b.sel = sel;
      b.dat = d0 + 32'(i);
      exp_beat.push_back(b);
      if (!we) exp_rd.push_back(pat(b.adr));
    end
  endtask

  task automatic load_wr(input logic [31:0] d0, input int n, input int dly1);
    wbeat_t w;
    for (int i = 0; i < n; i++) begin
      w.d   = d0 + 32'(i);
      w.dly = (i == 1) ? dly1 : 0;
      wq.push_back(w);
    end
    wdly       = 0;
    wr_valid_i = 1'b1;
    wr_data_i  = d0;
  endtask

  task automatic issue(input bit we, input logic [31:0] adr,
                       input logic [3:0] len, input logic [3:0] sel);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len;
    cmd_sel_i   = sel;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #2;
  endtask

  task automatic flush();
    exp_beat.delete();
    exp_rd.delete();
    rq.delete();
    wq.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready_o, cyc_o, stb_o, busy_o, done_o, wr_ready_o,
         rd_valid_o, we_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready_o, cyc_o, stb_o, busy_o, done_o, wr_ready_o,
                rd_valid_o, we_o});
    end
    checks++;
    if ({adr_o, dat_o, rd_data_o, sel_o, cti_o, bte_o, err_code_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got adr %08h dat %08h rd %08h sel %h cti %b err %b want all 0",
               adr_o, dat_o, rd_data_o, sel_o, cti_o, err_code_o);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    int w0 = n_wr, d0 = n_done;
    load_wr(32'h0000_001D, 1, 0);
    push_beats(1'b1, 32'h8, 0, 4'hF, 32'h0000_001D);
    issue(1'b1, 32'h8, 4'd0, 4'hF);
    wait_done(ok);
    checks++;
    if (!ok || n_done - d0 != 1 || n_wr - w0 != 1 || err_code_o !== 2'b00) begin
      errors++;
      $display("FAIL single_write: got ok %0d done %0d wr_ready %0d err %b want 1 1 1 00",
               ok, n_done - d0, n_wr - w0, err_code_o);
    end
    checks++;
    if (exp_beat.size() != 0) begin
      errors++;
      $display("FAIL single_write_beats: got %0d left want 0", exp_beat.size());
    end
    flush();
  endtask

  task automatic test_single_read_latency();
    push_beats(1'b0, 32'h4, 0, 4'h3, 32'h0);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h7;
    cmd_len_i   = 4'd0;
    cmd_sel_i   = 4'h3;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    #2;
    checks++;
    if ({cyc_o, stb_o, busy_o, cmd_ready_o} !== 4'b1110) begin
      errors++;
      $display("FAIL lat_t1: got %b want 1110", {cyc_o, stb_o, busy_o, cmd_ready_o});
    end
    @(negedge clk);
    #2;
    checks++;
    if ({ack_i, rd_valid_o, done_o} !== 3'b100) begin
      errors++;
      $display("FAIL lat_t2: got %b want 100", {ack_i, rd_valid_o, done_o});
    end
    @(negedge clk);
    #2;
    checks++;
    if ({rd_valid_o, done_o, cyc_o, cmd_ready_o} !== 4'b1100) begin
      errors++;
      $display("FAIL lat_t3: got %b want 1100", {rd_valid_o, done_o, cyc_o, cmd_ready_o});
    end
    @(negedge clk);
    #2;
    checks++;
    if ({cmd_ready_o, done_o, busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL lat_t4: got %b want 100", {cmd_ready_o, done_o, busy_o});
    end
    flush();
  endtask

  task automatic test_read_burst();
    bit ok;
    int r0 = n_rd, d0 = n_done;
    push_beats(1'b0, 32'h10, 3, 4'hF, 32'h0);
    issue(1'b0, 32'h10, 4'd3, 4'hF);
    // A second request while busy must be ignored.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'hDEAD_BEE0;
    cmd_len_i   = 4'd7;
    @(negedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || n_rd - r0 != 4 || n_done - d0 != 1 || err_code_o !== 2'b00) begin
      errors++;
      $display("FAIL read_burst: got ok %0d rd %0d done %0d err %b want 1 4 1 00",
               ok, n_rd - r0, n_done - d0, err_code_o);
    end
    checks++;
    if (exp_beat.size() != 0 || exp_rd.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL read_burst_left: got beats %0d rd %0d busy %b want 0 0 0",
               exp_beat.size(), exp_rd.size(), busy_o);
    end
    flush();
  endtask

  task automatic test_write_stall();
    bit ok;
    int w0 = n_wr, q0 = n_wait;
    load_wr(32'hA000_1000, 3, 3);
    push_beats(1'b1, 32'h20, 2, 4'hC, 32'hA000_1000);
    issue(1'b1, 32'h20, 4'd2, 4'hC);
    wait_done(ok);
    checks++;
    if (!ok || n_wr - w0 != 3 || n_wait - q0 != 3 || err_code_o !== 2'b00) begin
      errors++;
      $display("FAIL write_stall: got ok %0d wr_ready %0d wait %0d err %b want 1 3 3 00",
               ok, n_wr - w0, n_wait - q0, err_code_o);
    end
    checks++;
    if (exp_beat.size() != 0) begin
      errors++;
      $display("FAIL write_stall_beats: got %0d left want 0", exp_beat.size());
    end
    flush();
  endtask

  task automatic test_retry();
    bit ok;
    int r0 = n_rd, q0 = n_wait;
    rq = '{1, 1, 0};
    push_beats(1'b0, 32'h40, 0, 4'hF, 32'h0);
    issue(1'b0, 32'h40, 4'd0, 4'hF);
    wait_done(ok);
    checks++;
    if (!ok || n_rd - r0 != 1 || n_wait - q0 != 2 || err_code_o !== 2'b00) begin
      errors++;
      $display("FAIL retry_ok: got ok %0d rd %0d backoff %0d err %b want 1 1 2 00",
               ok, n_rd - r0, n_wait - q0, err_code_o);
    end
    flush();
    r0 = n_rd;
    q0 = n_wait;
    rq = '{1, 1, 1, 1};
    push_beats(1'b0, 32'h44, 0, 4'hF, 32'h0);
    issue(1'b0, 32'h44, 4'd0, 4'hF);
    wait_done(ok);
    checks++;
    if (!ok || n_rd - r0 != 0 || n_wait - q0 != 3 || err_code_o !== 2'b10) begin
      errors++;
      $display("FAIL retry_exhaust: got ok %0d rd %0d backoff %0d err %b want 1 0 3 10",
               ok, n_rd - r0, n_wait - q0, err_code_o);
    end
    flush();
  endtask

  task automatic test_bus_err();
    bit seen = 1'b0;
    int w0 = n_wr, d0 = n_done;
    rq = '{0, 2};
    load_wr(32'h0BAD_0000, 4, 0);
    push_beats(1'b1, 32'h80, 3, 4'hF, 32'h0BAD_0000);
    issue(1'b1, 32'h80, 4'd3, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (err_i) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #2;
    checks++;
    if (!seen || cyc_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL err_drop: got seen %0d cyc %b done %b want 1 0 1", seen, cyc_o, done_o);
    end
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (n_wr - w0 != 2 || n_done - d0 != 1 || err_code_o !== 2'b01) begin
      errors++;
      $display("FAIL err_term: got wr_ready %0d done %0d err %b want 2 1 01",
               n_wr - w0, n_done - d0, err_code_o);
    end
    flush();
  endtask

  task automatic test_mid_reset();
    int d0 = n_done;
    push_beats(1'b0, 32'h100, 3, 4'hF, 32'h0);
    issue(1'b0, 32'h100, 4'd3, 4'hF);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got cyc %b want 1", cyc_o);
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({cyc_o, stb_o, cmd_ready_o, busy_o} !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset: got %b want 0010", {cyc_o, stb_o, cmd_ready_o, busy_o});
    end
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (n_done - d0 != 0 || cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: got done %0d cyc %b want 0 0", n_done - d0, cyc_o);
    end
    flush();
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int nstb = 0;
    bit ok = 1'b0;
    rq = '{3};
    issue(1'b0, 32'h200, 4'd0, 4'hF);
    if (stb_o) nstb++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (stb_o) nstb++;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || nstb != 8 || err_code_o !== 2'b11) begin
      errors++;
      $display("FAIL timeout: got ok %0d strobes %0d err %b want 1 8 11", ok, nstb, err_code_o);
    end
    flush();
  endtask
`endif

  initial begin
    reset_n_i   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_len_i   = '0;
    cmd_sel_i   = '0;
    wr_data_i   = '0;
    wr_valid_i  = 1'b0;
    dat_i       = '0;
    ack_i       = 1'b0;
    err_i       = 1'b0;
    rty_i       = 1'b0;
    wdly        = 0;
    took        = 1'b0;
    fork
      forever begin
        @(posedge clk);
        took = wr_valid_i && wr_ready_o;
        slave_step();
        @(negedge clk);
        drive_wr();
        #1;
        monitor();
      end
    join_none
    repeat (3) @(negedge clk);
    #2;
    test_reset();
    reset_n_i = 1'b1;
    @(negedge clk);
    #2;
    test_single_write();
    test_single_read_latency();
    test_read_burst();
    test_write_stall();
    test_retry();
    test_bus_err();
    test_mid_reset();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_master.md
Name: wishbone_master

Overview:
- Wishbone B3 initiator that turns local command requests into single or incrementing-burst bus cycles toward the PCI-side register slaves (SPI control, JTAG mux, trigger registers).
- Sits between an on-board sequencer and the shared Wishbone bus.
- Handles byte selects, cti/bte signalling, err/rty termination and bounded retries.
- Returns read data and completion status to the requester.

Parameters:
- LEN_W, 4, width of cmd_len_i; a burst is at most 2^LEN_W beats.
- MAX_RETRY, 3, number of rty_i terminations tolerated per beat before the command aborts.
- TIMEOUT_CYCLES, 255, strobe-without-termination limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high in IDLE; command accepted when cmd_valid_i & cmd_ready_o
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address of first beat, bits [1:0] ignored
- cmd_len_i  in  LEN_W  number of beats minus 1
- cmd_sel_i  in  4  byte select applied to every beat
- wr_data_i  in  32  write beat data
- wr_valid_i  in  1  write beat available
- wr_ready_o  out  1  one-cycle pulse, write beat consumed
- rd_data_o  out  32  read beat data
- rd_valid_o  out  1  one-cycle pulse per read beat; no back-pressure
- done_o  out  1  one-cycle pulse at command end, success or failure
- err_code_o  out  2  00 ok, 01 bus err, 10 retries exhausted, 11 timeout; held until next accept
- busy_o  out  1  command in progress
- cyc_o, stb_o, we_o  out  1 each  Wishbone controls
- adr_o  out  32  Wishbone address
- dat_o  out  32  Wishbone write data
- sel_o  out  4  Wishbone byte select
- cti_o  out  3  cycle type identifier
- bte_o  out  2  burst type extension
- dat_i  in  32  Wishbone read data
- ack_i, err_i, rty_i  in  1 each  Wishbone terminations

Behaviour:
- Reset, asynchronous with reset_n_i low: all outputs 0 except cmd_ready_o = 1; FSM to IDLE; all counters cleared. Reset mid-cycle drops cyc_o/stb_o immediately. No done_o is generated for the dropped command.
- FSM states: IDLE, FETCH, STROBE, BACKOFF, FINISH.
- IDLE: on accept, latch we, adr & ~3, len, sel; clear beat counter, retry counter and err_code_o. Go to FETCH for a write, STROBE for a read. cyc_o rises on the cycle after accept.
- FETCH (write only): cyc_o = 1, stb_o = 0. When wr_valid_i is high, latch wr_data_i into dat_o, pulse wr_ready_o, and go to STROBE next cycle.
- STROBE: stb_o = 1 with adr_o, we_o, sel_o and cti_o stable until a termination arrives.
  - cti_o = 000 when len = 0.
  - Otherwise cti_o = 010 on non-final beats and 111 on the final beat.
  - bte_o is always 00 (linear).
- Termination priority when several are high in the same cycle: err_i > rty_i > ack_i.
- ack_i:
  - For a read, register dat_i to rd_data_o and pulse rd_valid_o the next cycle.
  - If this was the final beat, go to FINISH.
  - Otherwise add 4 to adr_o (32-bit wrap allowed), increment the beat counter, clear the retry counter, and go to FETCH (write) or stay in STROBE (read; back-to-back strobes are allowed).
- rty_i: go to BACKOFF for one cycle with stb_o = 0 and cyc_o = 1, then re-issue the same beat with identical adr_o/dat_o; the retry counter increments.
  - If the retry counter is already MAX_RETRY, set err_code_o = 10 and go to FINISH.
  - A write beat is never re-fetched on retry.
- err_i: set err_code_o = 01 and go to FINISH. Remaining beats are abandoned; no further wr_ready_o or rd_valid_o pulses occur.
- FINISH: cyc_o = 0, stb_o = 0, done_o pulses, next state IDLE.
  - cmd_ready_o rises on the cycle after done_o.
  - Minimum idle gap between commands is 1 cycle.
- busy_o = not IDLE.
- cmd_valid_i is ignored while busy.
- Latency, single read against a slave with a registered ack: accept at T0; cyc/stb at T1; ack at T2; rd_valid_o at T3; done_o at T3.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined: a counter runs while in STROBE and clears on any termination or beat change. At TIMEOUT_CYCLES without a termination, set err_code_o = 11 and go to FINISH.
- Undefined: no counter logic; the master waits indefinitely for a termination, and code 11 is never produced.

Test Plan:
- Single write: adr 0x008, sel 0xF, data 0x0000001D, slave acks after 1 cycle -> cti 000, one wr_ready_o pulse, done_o, err_code 00.
- 4-beat read: adr 0x010, len 3 -> adr_o 0x010/0x014/0x018/0x01C, cti 010,010,010,111, four rd_valid_o pulses carrying slave data, done_o after the 4th.
- Write burst, len 2, wr_valid_i delayed 3 cycles before beat 2 -> stb_o low with cyc_o high during the wait, exactly 3 wr_ready_o pulses, adr_o increments by 4 per beat.
- Retry: slave returns rty twice then ack on a single read -> two BACKOFF gaps, same adr_o each time, err_code 00. With 4 rty (MAX_RETRY = 3) -> err_code 10, no rd_valid_o.
- err_i on beat 2 of a 4-beat write -> cyc_o drops the next cycle, err_code 01, 2 wr_ready_o total, done_o once.
- reset_n_i asserted mid-burst -> cyc_o/stb_o 0 in the same cycle, cmd_ready_o 1, no done_o. With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a silent slave -> done_o with err_code 11 after 8 strobe cycles.
